// File: rtl/wb_mem_responder_if.sv
// -----------------------------------------------------------------------------
// wb_mem_responder_if
//   Wishbone B4 pipelined bus bundle between the load-store unit (master) and
//   the memory responder (slave). Signal names keep the slave-side _i/_o
//   suffixes so the responder reads like the bus definition.
//
//   wb_adr_i   [31:0]  byte address (master -> slave)
//   wb_dat_i   [31:0]  write data   (master -> slave)
//   wb_we_i            1 = write    (master -> slave)
//   wb_sel_i   [3:0]   byte lanes   (master -> slave)
//   wb_stb_i           request      (master -> slave)
//   wb_cyc_i           cycle active (master -> slave)
//   wb_dat_o   [31:0]  read data    (slave -> master)
//   wb_ack_o           acknowledge  (slave -> master)
//   wb_stall_o         stall        (slave -> master)
// -----------------------------------------------------------------------------
interface wb_mem_responder_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_stall_o;

    modport slave (
        input  wb_adr_i,
        input  wb_dat_i,
        input  wb_we_i,
        input  wb_sel_i,
        input  wb_stb_i,
        input  wb_cyc_i,
        output wb_dat_o,
        output wb_ack_o,
        output wb_stall_o
    );

    modport master (
        output wb_adr_i,
        output wb_dat_i,
        output wb_we_i,
        output wb_sel_i,
        output wb_stb_i,
        output wb_cyc_i,
        input  wb_dat_o,
        input  wb_ack_o,
        input  wb_stall_o
    );
endinterface

// File: rtl/wb_mem_responder.sv
// -----------------------------------------------------------------------------
// wb_mem_responder
//   Wishbone B4 pipelined slave backing a word-organised memory of
//   2^ADDR_WIDTH 32-bit words with byte-lane writes. Accepted requests are
//   queued in a FIFO_DEPTH-entry FIFO and acknowledged strictly in order,
//   LATENCY cycles after each request becomes the FIFO head.
//
// Ports
//   clk_i   clock, rising edge
//   rst_i   synchronous active-high reset (FIFO and timing state only;
//           memory contents are kept)
//   wb      wb_mem_responder_if.slave bus bundle
//
// Parameters
//   ADDR_WIDTH  word-index bits (depth 2^ADDR_WIDTH words)
//   LATENCY     head-to-ack cycles, 1..4
//   FIFO_DEPTH  outstanding requests, 2..8, power of two
//
// Build option
//   WB_MEM_STALL_INJECT_EN  when defined, a free-running 2-bit counter forces
//                           stall on every 4th cycle (counter == 3) to stress
//                           initiator stall handling. Acks are unaffected.
// -----------------------------------------------------------------------------
module wb_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    wb_mem_responder_if.slave   wb
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int HC_W  = 2;
    localparam logic [HC_W-1:0]  HEAD_LOAD = HC_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam int MEM_WORDS = 1 << ADDR_WIDTH;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [31:0]           r_mem   [MEM_WORDS];

    logic [ADDR_WIDTH-1:0] r_q_idx [FIFO_DEPTH];
    logic                  r_q_we  [FIFO_DEPTH];
    logic [3:0]            r_q_sel [FIFO_DEPTH];
    logic [31:0]           r_q_dat [FIFO_DEPTH];

    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [HC_W-1:0]       r_head_cnt;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic                  w_head_valid;
    logic                  w_full;
    logic                  w_stall;
    logic                  w_push;
    logic                  w_ack;
    logic [ADDR_WIDTH-1:0] w_push_idx;
    logic [ADDR_WIDTH-1:0] w_head_idx;
    logic                  w_head_we;
    logic [3:0]            w_head_sel;
    logic [31:0]           w_head_dat;
    logic                  w_unused_adr;

    assign w_push_idx   = wb.wb_adr_i[ADDR_WIDTH+1:2];
    // Upper address bits alias and the byte offset is ignored.
    assign w_unused_adr = ^{wb.wb_adr_i[31:ADDR_WIDTH+2], wb.wb_adr_i[1:0]};

    assign w_head_valid = (r_count != '0);
    assign w_full       = (r_count == CNT_FULL);
    assign w_head_idx   = r_q_idx[r_rd_ptr];
    assign w_head_we    = r_q_we[r_rd_ptr];
    assign w_head_sel   = r_q_sel[r_rd_ptr];
    assign w_head_dat   = r_q_dat[r_rd_ptr];

`ifdef WB_MEM_STALL_INJECT_EN
    logic [1:0] r_inj_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_inj_cnt <= 2'd0;
        end else begin
            r_inj_cnt <= r_inj_cnt + 2'd1;
        end
    end

    assign w_stall = w_full | (r_inj_cnt == 2'd3);
`else
    // Full is taken from the registered count only, so a retire in the
    // same cycle does not open a slot early.
    assign w_stall = w_full;
`endif

    assign w_push = wb.wb_cyc_i & wb.wb_stb_i & ~w_stall & ~rst_i;
    // An ack while reset is asserted would be for a request being dropped.
    assign w_ack  = w_head_valid & (r_head_cnt == '0) & wb.wb_cyc_i & ~rst_i;

    assign wb.wb_ack_o   = w_ack;
    assign wb.wb_stall_o = w_stall;
    assign wb.wb_dat_o   = (w_ack && !w_head_we) ? r_mem[w_head_idx] : 32'h0;

    // ------------------------------------------------------------------
    // FIFO control and head latency counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_head_cnt <= '0;
        end else if (!wb.wb_cyc_i) begin
            // Cycle abort: every unretired request is discarded.
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_head_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_ack) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end

            case ({w_push, w_ack})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // A new head is formed either by the old head retiring with
            // something behind it (already queued or pushed this edge), or
            // by a push into an empty FIFO. Otherwise count down to zero.
            if (w_ack) begin
                if ((r_count > CNT_W'(1)) || w_push) begin
                    r_head_cnt <= HEAD_LOAD;
                end
            end else if (w_push && !w_head_valid) begin
                r_head_cnt <= HEAD_LOAD;
            end else if (w_head_valid && (r_head_cnt != '0)) begin
                r_head_cnt <= r_head_cnt - HC_W'(1);
            end
        end
    end

    // Request payload: no reset needed, validity is tracked by r_count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_q_idx[r_wr_ptr] <= w_push_idx;
            r_q_we[r_wr_ptr]  <= wb.wb_we_i;
            r_q_sel[r_wr_ptr] <= wb.wb_sel_i;
            r_q_dat[r_wr_ptr] <= wb.wb_dat_i;
        end
    end

    // ------------------------------------------------------------------
    // Memory: written only when a write retires; contents survive reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_ack && w_head_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_head_sel[b]) begin
                    r_mem[w_head_idx][8*b +: 8] <= w_head_dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_mem_responder.sv
module tb_wb_mem_responder;

    localparam int TB_AW    = 10;
    localparam int TB_LAT   = 3;
    localparam int TB_DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_mem_responder_if bus ();

    wb_mem_responder #(
        .ADDR_WIDTH (TB_AW),
        .LATENCY    (TB_LAT),
        .FIFO_DEPTH (TB_DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (bus.slave)
    );

    // Reference model: each accepted request is acked at
    //   max(accept cycle, ack cycle of the request ahead of it) + LATENCY
    // as long as cyc stays high; dropping cyc or reset empties the queue.
    typedef struct {
        logic             we;
        logic [TB_AW-1:0] idx;
        logic [3:0]       sel;
        logic [31:0]      dat;
        int               ack_at;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_mem [1 << TB_AW];
    int          tail_ack;
    int          cyc_no;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_acks  = 0;
    int          last_ack_cyc;
    int          last_acc_cyc;
    logic [31:0] last_rd;
    int          ack_log[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc_no);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] pre_val(input int i);
        return (i == 8) ? 32'h1122_3344 : (32'hA5A5_0000 | i);
    endfunction

    // One bus cycle: drive, sample mid-cycle, compare, advance the model.
    task automatic tick(input logic cyc, input logic stb, input logic we,
                        input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic acc);
        logic        exp_stall;
        logic        exp_ack;
        logic [31:0] exp_dat;
        ent_t        e;
        bus.wb_cyc_i = cyc;
        bus.wb_stb_i = stb;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        @(negedge clk);
        exp_stall = (mq.size() == TB_DEPTH);
`ifdef WB_MEM_STALL_INJECT_EN
        if ((cyc_no % 4) == 3) exp_stall = 1'b1;
`endif
        exp_ack = cyc && (mq.size() > 0) && (mq[0].ack_at == cyc_no);
        exp_dat = (exp_ack && !mq[0].we) ? m_mem[mq[0].idx] : 32'h0;
        check("stall", {31'b0, bus.wb_stall_o}, {31'b0, exp_stall});
        check("ack",   {31'b0, bus.wb_ack_o},   {31'b0, exp_ack});
        check("dat_o", bus.wb_dat_o, exp_dat);
        if (bus.wb_ack_o) begin
            n_acks++;
            last_ack_cyc = cyc_no;
            last_rd      = bus.wb_dat_o;
            ack_log.push_back(cyc_no);
        end
        acc = cyc && stb && !exp_stall;
        @(posedge clk);
        #1;
        if (exp_ack) begin
            if (mq[0].we) m_mem[mq[0].idx] = merge(m_mem[mq[0].idx], mq[0].dat, mq[0].sel);
            void'(mq.pop_front());
        end
        if (!cyc) begin
            mq.delete();
            tail_ack = -100;
        end
        if (acc) begin
            e.we     = we;
            e.idx    = adr[TB_AW+1:2];
            e.sel    = sel;
            e.dat    = dat;
            e.ack_at = ((cyc_no > tail_ack) ? cyc_no : tail_ack) + TB_LAT;
            tail_ack = e.ack_at;
            mq.push_back(e);
            last_acc_cyc = cyc_no;
        end
        cyc_no++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        tail_ack = -100;
        cyc_no   = 0;
    endtask

    task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel);
        logic acc;
        int   k;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 50) begin
            tick(1'b1, 1'b1, we, adr, dat, sel, acc);
            k++;
        end
        check("accept", {31'b0, acc}, 32'h1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, acc);
    endtask

    task automatic drain();
        logic acc;
        int   k;
        k = 0;
        while (mq.size() > 0 && k < 100) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, acc);
            k++;
        end
        check("drain", mq.size(), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          a0;
        int          n0;
        logic        acc;
        logic [7:0]  pat;
        logic [7:0]  pat_exp;
        logic [31:0] r;
        logic [31:0] adr;
        int          idx;

        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 32'h0;
        bus.wb_dat_i = 32'h0;
        bus.wb_sel_i = 4'h0;
        tail_ack     = -100;
        cyc_no       = 0;
        last_rd      = 32'h0;
        last_ack_cyc = 0;
        last_acc_cyc = 0;

        // Idle stall pattern straight out of reset
        do_reset();
        pat = 8'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pat[i] = bus.wb_stall_o;
            if (i == 0) begin
                check("rst_ack",  {31'b0, bus.wb_ack_o}, 32'h0);
                check("rst_dat",  bus.wb_dat_o, 32'h0);
            end
            @(posedge clk);
            #1;
            cyc_no++;
        end
`ifdef WB_MEM_STALL_INJECT_EN
        pat_exp = 8'b1000_1000;
`else
        pat_exp = 8'b0000_0000;
`endif
        check("idle_stall", {24'b0, pat}, {24'b0, pat_exp});

        // Preload words 0..15
        for (int i = 0; i < 16; i++) send(1'b1, 32'(i * 4), pre_val(i), 4'hF);
        drain();

        // Single write then read with latency checks
        send(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        a0 = last_acc_cyc;
        drain();
        check("wr_latency", 32'(last_ack_cyc - a0), 32'(TB_LAT));
        send(1'b0, 32'h10, 32'h0, 4'hF);
        a0 = last_acc_cyc;
        drain();
        check("rd_latency", 32'(last_ack_cyc - a0), 32'(TB_LAT));
        check("rd_data", last_rd, 32'hDEAD_BEEF);

        // Byte lanes
        send(1'b1, 32'h20, 32'hAABB_CCDD, 4'h5);
        send(1'b0, 32'h20, 32'h0, 4'hF);
        drain();
        check("byte_lanes", last_rd, 32'h11BB_33DD);

        // Back-to-back stream into a full FIFO
        ack_log.delete();
        send(1'b0, 32'h00, 32'h0, 4'hF);
        a0 = last_acc_cyc;
        send(1'b0, 32'h04, 32'h0, 4'hF);
        send(1'b0, 32'h08, 32'h0, 4'hF);
        send(1'b0, 32'h0C, 32'h0, 4'hF);
        drain();
        check("stall_nacks", ack_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++)
            check($sformatf("stall_ack%0d", i), 32'(ack_log[i] - a0), 32'(TB_LAT * (i + 1)));

        // Abort: two writes accepted, cyc dropped before any ack
        n0 = n_acks;
        send(1'b1, 32'h30, 32'h1111_1111, 4'hF);
        send(1'b1, 32'h34, 32'h2222_2222, 4'hF);
        tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, acc);
        idle(6);
        check("abort_noack", 32'(n_acks - n0), 32'h0);
        send(1'b0, 32'h30, 32'h0, 4'hF);
        drain();
        check("abort_mem0", last_rd, pre_val(12));
        send(1'b0, 32'h34, 32'h0, 4'hF);
        drain();
        check("abort_mem1", last_rd, pre_val(13));

        // Reset with two reads pending
        send(1'b0, 32'h00, 32'h0, 4'hF);
        send(1'b0, 32'h04, 32'h0, 4'hF);
        do_reset();
        n0 = n_acks;
        idle(8);
        check("reset_noack", 32'(n_acks - n0), 32'h0);
        send(1'b0, 32'h10, 32'h0, 4'hF);
        drain();
        check("reset_read", last_rd, 32'hDEAD_BEEF);

        // Address aliasing
        send(1'b1, 32'h0000_1004, 32'hCAFE_F00D, 4'hF);
        send(1'b0, 32'h0000_0004, 32'h0, 4'hF);
        drain();
        check("alias", last_rd, 32'hCAFE_F00D);

        // Randomised traffic over the preloaded words
        for (int i = 0; i < 400; i++) begin
            r   = $urandom();
            idx = $urandom_range(0, 15);
            adr = (r & 32'hFFFF_F003) | (32'(idx) << 2);
            tick(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 1)), adr, $urandom(), 4'($urandom_range(0, 15)), acc);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
